// File: rtl/nios_system_sw_port_pkg.sv
// rtl/nios_system_sw_port_pkg.sv - register map and bit index constants for the sw output port
package nios_system_sw_port_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  localparam int STAT_EMPTY   = 8;
  localparam int STAT_FULL    = 9;
  localparam int STAT_OVF     = 10;

  localparam int CTRL_CLR_OVF = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_IRQ_EN  = 2;

endpackage

// File: rtl/nios_system_from_sw_port_if.sv
// rtl/nios_system_from_sw_port_if.sv - Avalon slave bus plus consumer valid/ready stream
interface nios_system_from_sw_port_if #(
  parameter int DATA_W = 32
) ();

  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  address, chipselect, write_n, writedata, out_ready,
    output readdata, out_data, out_valid
  );

  modport master (
    output address, chipselect, write_n, writedata, out_ready,
    input  readdata, out_data, out_valid
  );

endinterface

// File: rtl/nios_system_sw_port_fifo.sv
// rtl/nios_system_sw_port_fifo.sv - synchronous FIFO with flush; push allowed when full if popping
module nios_system_sw_port_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nios_system_from_sw_port.sv
// rtl/nios_system_from_sw_port.sv - Avalon write-only output port drained by hardware; irq with SW_PORT_IRQ_EN
module nios_system_from_sw_port
  import nios_system_sw_port_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic clk,
  input  logic reset,
`ifdef SW_PORT_IRQ_EN
  output logic irq,
`endif
  nios_system_from_sw_port_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr;
  logic              push;
  logic              ctrl_wr;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] head;
  logic              overflow;
  logic [DATA_W-1:0] consumed;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] ctrl_rd;
  logic [DATA_W-1:0] rd_mux;
  logic              irq_en;

  assign wr      = bus.chipselect & ~bus.write_n;
  assign push    = wr & (bus.address == ADDR_DATA);
  assign ctrl_wr = wr & (bus.address == ADDR_CTRL);
  assign pop     = bus.out_valid & bus.out_ready;

  assign bus.out_valid = ~empty;
  assign bus.out_data  = head;

  nios_system_sw_port_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.writedata),
    .pop       (pop),
    .flush     (ctrl_wr & bus.writedata[CTRL_FLUSH]),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  // A dropped push and a clear cannot share a cycle, so ordering only matters for clarity.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ctrl_wr && bus.writedata[CTRL_CLR_OVF]) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) consumed <= '0;
    else if (pop) consumed <= consumed + 1'b1;
  end

`ifdef SW_PORT_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= bus.writedata[CTRL_IRQ_EN];
      irq <= irq_en & (empty | overflow);
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  always_comb begin
    status              = '0;
    status[7:0]         = 8'(count);
    status[STAT_EMPTY]  = empty;
    status[STAT_FULL]   = full;
    status[STAT_OVF]    = overflow;
    ctrl_rd             = '0;
    ctrl_rd[CTRL_IRQ_EN] = irq_en;
    case (bus.address)
      ADDR_DATA:   rd_mux = empty ? '0 : head;
      ADDR_STATUS: rd_mux = status;
      ADDR_CTRL:   rd_mux = ctrl_rd;
      default:     rd_mux = consumed;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) bus.readdata <= '0;
    else bus.readdata <= rd_mux;
  end

endmodule
